// File: rtl/spi4_disp_rx_pkg.sv
// spi4_disp_rx_pkg: FSM states, synchroniser reset values and stats width for spi4_disp_rx.
package spi4_disp_rx_pkg;
   typedef enum logic {IDLE, SHIFT} state_e;
   localparam logic CS_RST  = 1'b1;
   localparam logic SCK_RST = 1'b0;
   localparam logic SDI_RST = 1'b0;
   localparam logic DC_RST  = 1'b0;
   localparam int STAT_W = 16;
endpackage

// File: rtl/spi4_disp_rx_fifo.sv
// spi4_disp_rx_fifo: receive FIFO with wrap-bit pointers; head output holds its last value while empty.
module spi4_disp_rx_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] hold_q, hold_d;
   logic wr_en, rd_en;
   always_comb begin
      empty_o = wr_q == rd_q;
      full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      wr_en   = push_i & ~clr_i & (~full_o | pop_i);
      rd_en   = pop_i & ~clr_i & ~empty_o;
      wr_d    = clr_i ? '0 : wr_q + {{AW{1'b0}}, wr_en};
      rd_d    = clr_i ? '0 : rd_q + {{AW{1'b0}}, rd_en};
      dout_o  = empty_o ? hold_q : mem_q[rd_q[AW-1:0]];
      hold_d  = dout_o;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         hold_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         hold_q <= hold_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/spi4_disp_rx.sv
// spi4_disp_rx: SPI mode-0 display receiver (words + dc flag) into a FIFO with sticky overflow/framing flags.
// Defining SPI4_DISP_RX_STATS_EN adds cmd_cnt_o/data_cnt_o accepted-word counters.
module spi4_disp_rx
   import spi4_disp_rx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n_i,
   input  logic              sck_i,
   input  logic              sdi_i,
   input  logic              dc_i,
   output logic [WIDTH-1:0]  word_o,
   output logic              dc_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic              clr_i,
`ifdef SPI4_DISP_RX_STATS_EN
   output logic [STAT_W-1:0] cmd_cnt_o,
   output logic [STAT_W-1:0] data_cnt_o,
`endif
   output logic              ovf_o,
   output logic              frm_err_o
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e state_q, state_d;
   logic [1:0] cs_q, cs_d, sck_q, sck_d, sdi_q, sdi_d, dc_q, dc_d;
   logic sck_prev_q, sck_prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic push_q, push_d;
   logic [WIDTH:0] pword_q, pword_d, head;
   logic ovf_q, ovf_d, frm_q, frm_d;
   logic full, empty, pop, sck_rise;
   always_comb begin
      cs_d       = {cs_q[0], cs_n_i};
      sck_d      = {sck_q[0], sck_i};
      sdi_d      = {sdi_q[0], sdi_i};
      dc_d       = {dc_q[0], dc_i};
      sck_prev_d = sck_q[1];
      sck_rise   = sck_q[1] & ~sck_prev_q;
      pop        = ready_i & ~empty;
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      push_d     = 1'b0;
      pword_d    = pword_q;
      ovf_d      = clr_i ? 1'b0 : ovf_q | (push_q & full & ~pop);
      frm_d      = clr_i ? 1'b0 : frm_q;
      case (state_q)
         IDLE: state_d = cs_q[1] ? IDLE : SHIFT;
         SHIFT: begin
            if (cs_q[1]) begin
               state_d = IDLE;
               cnt_d   = '0;
               frm_d   = frm_d | (cnt_q != '0);
            end else if (sck_rise) begin
               shift_d = {shift_q[WIDTH-2:0], sdi_q[1]};
               push_d  = cnt_q == CW'(WIDTH - 1);
               cnt_d   = push_d ? '0 : cnt_q + CW'(1);
               pword_d = push_d ? {dc_q[1], shift_d} : pword_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cs_q       <= {2{CS_RST}};
         sck_q      <= {2{SCK_RST}};
         sdi_q      <= {2{SDI_RST}};
         dc_q       <= {2{DC_RST}};
         sck_prev_q <= SCK_RST;
         cnt_q      <= '0;
         shift_q    <= '0;
         push_q     <= 1'b0;
         pword_q    <= '0;
         ovf_q      <= 1'b0;
         frm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_d;
         sck_q      <= sck_d;
         sdi_q      <= sdi_d;
         dc_q       <= dc_d;
         sck_prev_q <= sck_prev_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         push_q     <= push_d;
         pword_q    <= pword_d;
         ovf_q      <= ovf_d;
         frm_q      <= frm_d;
      end
   end
   spi4_disp_rx_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr_i),
      .push_i  (push_q),
      .pop_i   (pop),
      .din_i   (pword_q),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign word_o    = head[WIDTH-1:0];
   assign dc_o      = head[WIDTH];
   assign valid_o   = ~empty;
   assign ovf_o     = ovf_q;
   assign frm_err_o = frm_q;
`ifdef SPI4_DISP_RX_STATS_EN
   logic [STAT_W-1:0] cmd_q, cmd_d, data_q, data_d;
   logic acc;
   always_comb begin
      acc    = push_q & ~clr_i & (~full | pop);
      cmd_d  = clr_i ? '0 : cmd_q + STAT_W'(acc & ~pword_q[WIDTH]);
      data_d = clr_i ? '0 : data_q + STAT_W'(acc & pword_q[WIDTH]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q  <= '0;
         data_q <= '0;
      end else begin
         cmd_q  <= cmd_d;
         data_q <= data_d;
      end
   end
   assign cmd_cnt_o  = cmd_q;
   assign data_cnt_o = data_q;
`endif
endmodule
